pattern_moore_fsm: RTL and testbench

PATTERN_MOORE_FSM -- requirements
Module: pattern_moore_fsm

---
 rtl/pattern_fsm_pkg.sv | 29 ++
 rtl/pattern_next_state.sv | 50 +++++
 rtl/pattern_moore_fsm.sv | 106 ++++++++++
 tb/tb_pattern_moore_fsm.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_fsm_pkg.sv
// Shared definitions for the serial pattern detector.
// Contents:
//   op_e        - what the detector does on a given clock edge
//   state_width - bits needed to hold a matched-prefix count 0..pat_w
//   SW_DEFAULT  - state width for the default 8-bit pattern
//   clamp_len   - maps a requested pattern length into 1..pat_w
package pattern_fsm_pkg;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_SHIFT,
    OP_LOAD,
    OP_RESET
  } op_e;

  function automatic int state_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  localparam int SW_DEFAULT = state_width(8);

  // A zero-length pattern would match on every bit, so it is promoted to 1.
  function automatic int clamp_len(input int len, input int pat_w);
    if (len < 1) return 1;
    if (len > pat_w) return pat_w;
    return len;
  endfunction

endpackage

// File: rtl/pattern_next_state.sv
// Combinational prefix search for the pattern detector.
// Finds the longest pattern prefix that ends at the newest bit.
// Ports:
//   win        - in,  PAT_W : history window, newest bit (x) at bit 0
//   pat        - in,  PAT_W : pattern, pat[len-1] is the first bit
//   len        - in,  SW    : pattern length, always 1..PAT_W
//   ovl        - in,  1     : 1 = overlapping detection
//   state      - in,  SW    : currently matched prefix length
//   next_state - out, SW    : matched prefix length after this bit
module pattern_next_state
  import pattern_fsm_pkg::*;
#(
  parameter int PAT_W = 8,
  localparam int SW = state_width(PAT_W)
) (
  input  logic [PAT_W-1:0] win,
  input  logic [PAT_W-1:0] pat,
  input  logic [SW-1:0]    len,
  input  logic             ovl,
  input  logic [SW-1:0]    state,
  output logic [SW-1:0]    next_state
);

  int               limit;
  logic [PAT_W-1:0] mask;
  logic [PAT_W-1:0] expect_bits;

  // A prefix of length k matches when the k newest window bits equal
  // pat[len-1:len-k]. Shifting the pattern down by len-k lines that slice
  // up with win[k-1:0], and the mask keeps only those k bits. Candidates
  // are tried shortest first so the last hit is the longest one.
  // After a full match in non-overlap mode only a fresh start (k <= 1)
  // is allowed, so bits of the previous match are never reused.
  always_comb begin
    limit = int'(state) + 1;
    if (limit > int'(len)) limit = int'(len);
    if (!ovl && (state == len)) limit = 1;
    next_state  = '0;
    mask        = '0;
    expect_bits = '0;
    for (int k = 1; k <= PAT_W; k++) begin
      if (k <= limit) begin
        mask        = {PAT_W{1'b1}} >> (PAT_W - k);
        expect_bits = pat >> (int'(len) - k);
        if (((win ^ expect_bits) & mask) == '0) next_state = SW'(k);
      end
    end
  end

endmodule

// File: rtl/pattern_moore_fsm.sv
// Configurable serial pattern detector (Moore machine).
// Ports:
//   clk       - in,  1     : clock, rising edge
//   reset     - in,  1     : synchronous active-high reset
//   en        - in,  1     : sample x this cycle
//   x         - in,  1     : serial input bit
//   load      - in,  1     : latch pat_in/len_in/ovl_in and restart
//   pat_in    - in,  PAT_W : pattern, pat_in[len-1] is the first bit
//   len_in    - in,  SW    : pattern length (clamped to 1..PAT_W)
//   ovl_in    - in,  1     : 1 = overlapping detection
//   state     - out, SW    : matched prefix length 0..len
//   z         - out, 1     : match flag, high while state == len
//   match_cnt - out, CNT_W : saturating count of matches
module pattern_moore_fsm
  import pattern_fsm_pkg::*;
#(
  parameter int               PAT_W   = 8,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = 8'b0001_0101,
  parameter int               DEF_LEN = 5,
  parameter bit               DEF_OVL = 1'b1,
  localparam int SW = state_width(PAT_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  input  logic             load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [SW-1:0]    len_in,
  input  logic             ovl_in,
  output logic [SW-1:0]    state,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt
);

  logic [PAT_W-1:0] pat_q;
  logic [SW-1:0]    len_q;
  logic             ovl_q;
  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] win;
  logic [SW-1:0]    nxt;
  logic [SW-1:0]    len_clamped;
  op_e              op;

  // The oldest history bit drops out of every window once x is shifted in;
  // it is still part of the register so the history keeps PAT_W bits.
  logic unused_hist_msb;
  assign unused_hist_msb = hist[PAT_W-1];

  assign win         = {hist[PAT_W-2:0], x};
  assign len_clamped = SW'(clamp_len(int'(len_in), PAT_W));

  pattern_next_state #(
    .PAT_W(PAT_W)
  ) u_next (
    .win       (win),
    .pat       (pat_q),
    .len       (len_q),
    .ovl       (ovl_q),
    .state     (state),
    .next_state(nxt)
  );

  // Reset beats load, load beats en; with none asserted everything holds.
  always_comb begin
    op = OP_HOLD;
    if (reset)     op = OP_RESET;
    else if (load) op = OP_LOAD;
    else if (en)   op = OP_SHIFT;
  end

  // z is registered alongside state from the same next-state value, so it
  // equals (state == len) without any combinational path from x.
  always_ff @(posedge clk) begin
    unique case (op)
      OP_RESET: begin
        pat_q     <= DEF_PAT;
        len_q     <= SW'(clamp_len(DEF_LEN, PAT_W));
        ovl_q     <= DEF_OVL;
        hist      <= '0;
        state     <= '0;
        z         <= 1'b0;
        match_cnt <= '0;
      end
      OP_LOAD: begin
        pat_q     <= pat_in;
        len_q     <= len_clamped;
        ovl_q     <= ovl_in;
        hist      <= '0;
        state     <= '0;
        z         <= 1'b0;
        match_cnt <= '0;
      end
      OP_SHIFT: begin
        hist  <= win;
        state <= nxt;
        z     <= (nxt == len_q);
        if ((nxt == len_q) && (match_cnt != '1)) match_cnt <= match_cnt + CNT_W'(1);
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_pattern_moore_fsm.sv
// Self-checking bench for pattern_moore_fsm.
// Two instances share the stimulus: the default one and one with a 2-bit
// match counter. The reference model keeps the bits seen since the last
// restart and takes the longest suffix that is a pattern prefix.
module tb_pattern_moore_fsm;

  localparam int PAT_W = 8;
  localparam int CNT_W = 8;
  localparam int SW    = $clog2(PAT_W + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             en = 1'b0;
  logic             x = 1'b0;
  logic             load = 1'b0;
  logic [PAT_W-1:0] pat_in = '0;
  logic [SW-1:0]    len_in = '0;
  logic             ovl_in = 1'b0;
  logic [SW-1:0]    state, state2;
  logic             z, z2;
  logic [CNT_W-1:0] match_cnt;
  logic [1:0]       match_cnt2;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [PAT_W-1:0] m_pat;
  int               m_len;
  bit               m_ovl;
  int               m_state;
  int               m_cnt;
  int               m_cnt2;
  bit               seq[$];
  bit               q[$];

  always #5 clk = ~clk;

  pattern_moore_fsm dut (
    .clk(clk), .reset(reset), .en(en), .x(x), .load(load),
    .pat_in(pat_in), .len_in(len_in), .ovl_in(ovl_in),
    .state(state), .z(z), .match_cnt(match_cnt)
  );

  pattern_moore_fsm #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .x(x), .load(load),
    .pat_in(pat_in), .len_in(len_in), .ovl_in(ovl_in),
    .state(state2), .z(z2), .match_cnt(match_cnt2)
  );

  // expected bits in arrival order
  function automatic void rebuildSeq();
    logic [PAT_W-1:0] tmp;
    seq.delete();
    for (int i = 0; i < m_len; i++) begin
      tmp = m_pat >> (m_len - 1 - i);
      seq.push_back(tmp[0]);
    end
  endfunction

  function automatic int longestPrefix();
    int n;
    int kmax;
    bit ok;
    n    = q.size();
    kmax = (n < m_len) ? n : m_len;
    for (int k = kmax; k >= 1; k--) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++)
        if (q[n - k + i] != seq[i]) ok = 1'b0;
      if (ok) return k;
    end
    return 0;
  endfunction

  function automatic void modelStep(input bit r, input bit l, input bit e, input bit xv);
    if (r) begin
      m_pat = 8'b0001_0101;
      m_len = 5;
      m_ovl = 1'b1;
    end else if (l) begin
      m_pat = pat_in;
      m_len = (len_in == 0) ? 1 : ((int'(len_in) > PAT_W) ? PAT_W : int'(len_in));
      m_ovl = ovl_in;
    end
    if (r || l) begin
      rebuildSeq();
      q.delete();
      m_state = 0;
      m_cnt   = 0;
      m_cnt2  = 0;
    end else if (e) begin
      if (!m_ovl && (m_state == m_len)) q.delete();
      q.push_back(xv);
      while (q.size() > m_len) void'(q.pop_front());
      m_state = longestPrefix();
      if (m_state == m_len) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
  endfunction

  task automatic checkOutput();
    assert (state === SW'(m_state)) else begin
      errors++;
      $error("[TB] FAIL state: got %0d expected %0d", state, m_state);
    end
    checks++;
    assert (z === (m_state == m_len)) else begin
      errors++;
      $error("[TB] FAIL z: got %b expected %b", z, (m_state == m_len));
    end
    checks++;
    assert (match_cnt === CNT_W'(m_cnt)) else begin
      errors++;
      $error("[TB] FAIL match_cnt: got %0d expected %0d", match_cnt, m_cnt);
    end
    checks++;
    assert (state2 === SW'(m_state)) else begin
      errors++;
      $error("[TB] FAIL state2: got %0d expected %0d", state2, m_state);
    end
    checks++;
    assert (z2 === (m_state == m_len)) else begin
      errors++;
      $error("[TB] FAIL z2: got %b expected %b", z2, (m_state == m_len));
    end
    checks++;
    assert (match_cnt2 === 2'(m_cnt2)) else begin
      errors++;
      $error("[TB] FAIL match_cnt2: got %0d expected %0d", match_cnt2, m_cnt2);
    end
    checks++;
  endtask

  // direct check of a value fixed by hand-derived expectations
  task automatic expectValue(input string tag, input int got, input int exp);
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
    checks++;
  endtask

  task automatic applyStimulus(input bit r, input bit l, input bit e, input bit xv);
    reset = r;
    load  = l;
    en    = e;
    x     = xv;
    @(posedge clk);
    modelStep(r, l, e, xv);
    #1;
    checkOutput();
  endtask

  task automatic loadConfig(input logic [PAT_W-1:0] p, input logic [SW-1:0] ln, input bit o);
    pat_in = p;
    len_in = ln;
    ovl_in = o;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic feedBits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) applyStimulus(1'b0, 1'b0, 1'b1, bits[i]);
  endtask

  initial begin
    bit nb;
    bit e;

    // reset and defaults
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    expectValue("reset_state", int'(state), 0);
    expectValue("reset_cnt", int'(match_cnt), 0);

    // default pattern 10101, overlapping
    feedBits(16'b10101, 5);
    expectValue("def_z_bit5", int'(z), 1);
    expectValue("def_state_bit5", int'(state), 5);
    feedBits(16'b0, 1);
    expectValue("def_state_bit6", int'(state), 4);
    feedBits(16'b1, 1);
    expectValue("def_state_bit7", int'(state), 5);
    expectValue("def_cnt", int'(match_cnt), 2);

    // pattern 11, non-overlap then overlap
    loadConfig(8'b11, SW'(2), 1'b0);
    feedBits(16'b1111, 4);
    expectValue("nonovl_cnt", int'(match_cnt), 2);
    loadConfig(8'b11, SW'(2), 1'b1);
    feedBits(16'b1111, 4);
    expectValue("ovl_cnt", int'(match_cnt), 3);

    // hold while en is low
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    feedBits(16'b101, 3);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'(i % 2 == 0));
    expectValue("hold_state", int'(state), 3);
    feedBits(16'b01, 2);
    expectValue("hold_z", int'(z), 1);
    expectValue("hold_cnt", int'(match_cnt), 1);

    // counter saturation on the 2-bit instance
    loadConfig(8'b1, SW'(1), 1'b1);
    feedBits(16'b11111, 5);
    expectValue("sat_cnt2", int'(match_cnt2), 3);
    expectValue("sat_z2", int'(z2), 1);
    expectValue("sat_cnt", int'(match_cnt), 5);

    // length clamping
    loadConfig(8'hFE, SW'(0), 1'b0);
    feedBits(16'b1, 1);
    expectValue("len0_miss", int'(z), 0);
    feedBits(16'b0, 1);
    expectValue("len0_hit", int'(z), 1);
    loadConfig(8'hA5, SW'(PAT_W + 3), 1'b0);
    feedBits(16'hA5, 8);
    expectValue("lenmax_state", int'(state), PAT_W);
    expectValue("lenmax_z", int'(z), 1);

    // reset and load mid-pattern with en high
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    feedBits(16'b1010, 4);
    expectValue("mid_state4a", int'(state), 4);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    expectValue("mid_reset_state", int'(state), 0);
    feedBits(16'b1010, 4);
    pat_in = 8'b0001_0101;
    len_in = SW'(5);
    ovl_in = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    expectValue("mid_load_state", int'(state), 0);
    expectValue("mid_load_z", int'(z), 0);

    // randomized configurations and streams, biased toward the pattern
    for (int r = 0; r < 8; r++) begin
      loadConfig(PAT_W'($urandom), SW'($urandom_range(0, (r % 2 == 0) ? 4 : PAT_W + 3)),
                 1'($urandom_range(0, 1)));
      for (int s = 0; s < 80; s++) begin
        nb = (m_state < m_len) ? seq[m_state] : seq[0];
        if ($urandom_range(0, 3) == 0) nb = 1'($urandom_range(0, 1));
        e = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 99) == 0) begin
          applyStimulus(1'b1, 1'b0, e, nb);
        end else if ($urandom_range(0, 63) == 0) begin
          pat_in = PAT_W'($urandom);
          len_in = SW'($urandom_range(0, 5));
          ovl_in = 1'($urandom_range(0, 1));
          applyStimulus(1'b0, 1'b1, e, nb);
        end else begin
          applyStimulus(1'b0, 1'b0, e, nb);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
